// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared definitions for the ysyx_22050039 instruction fetch unit:
// FSM state encoding, reset PC, the nop word and the sequential PC step.
package ysyx_22050039_ifu_pkg;

   localparam int          XLEN_DEF     = 64;
   localparam int          INST_LEN_DEF = 32;
   localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [63:0] PC_INC       = 64'd4;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/ysyx_22050039_PCReg.sv
// Plain XLEN-wide register with write enable, asynchronously reset
// (active low) to the boot PC. Used for both the fetch PC and inst_pc.
module ysyx_22050039_PCReg
   import ysyx_22050039_ifu_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            wen_i,
   input  logic [XLEN-1:0] d_i,
   output logic [XLEN-1:0] q_o
);

   logic [XLEN-1:0] value_q;

   // Load a new value when enabled, otherwise hold.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q <= RESET_PC;
      end else if (wen_i) begin
         value_q <= d_i;
      end
   end

   assign q_o = value_q;

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: one outstanding imem read at a time, presents
// the fetched word and its PC to the IDU, and follows redirects by
// discarding any instruction still in flight from the old path.
module ysyx_22050039_ifu
   import ysyx_22050039_ifu_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEF,
   parameter int               INST_LEN = INST_LEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_resp_valid,
   input  logic [INST_LEN-1:0] imem_resp_data,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [INST_LEN-1:0] inst,
   output logic [XLEN-1:0]     inst_pc,
   input  logic                pc_wen,
   input  logic [XLEN-1:0]     pc_target,
   output logic                fetch_fault
);

   ifu_state_e          state_q;
   logic                kill_q;
   logic                started_q;
   logic                redirPend_q;
   logic [XLEN-1:0]     redirTarget_q;
   logic                instValid_q;
   logic [INST_LEN-1:0] inst_q;
   logic                fault_q;

   logic [XLEN-1:0]     pc_q;
   logic [XLEN-1:0]     pc_d;
   logic                pcWe;
   logic [XLEN-1:0]     instPc_q;
   logic                instPcWe;

   logic                misalign;
   logic                redirect;
   logic                reqFire;

   assign misalign = pc_wen && (pc_target[1:0] != 2'b00);
   assign redirect = pc_wen && !misalign;
   // started_q keeps the request low during reset and until the first edge after it.
   assign reqFire  = (state_q == ST_REQ) && started_q && imem_req_ready;

   // Next fetch PC: redirect beats the sequential step; a redirect seen while
   // an unaccepted request is on the bus is parked and applied on acceptance
   // so the request address never moves under the memory.
   always_comb begin
      pcWe     = 1'b0;
      pc_d     = pc_q;
      instPcWe = 1'b0;
      if ((state_q != ST_FAULT) && !misalign) begin
         case (state_q)
            ST_REQ: begin
               if (!started_q) begin
                  if (redirect) begin
                     pcWe = 1'b1;
                     pc_d = pc_target;
                  end
               end else if (reqFire) begin
                  if (redirect) begin
                     pcWe = 1'b1;
                     pc_d = pc_target;
                  end else if (redirPend_q) begin
                     pcWe = 1'b1;
                     pc_d = redirTarget_q;
                  end
               end
            end
            ST_WAIT: begin
               if (redirect) begin
                  pcWe = 1'b1;
                  pc_d = pc_target;
               end else if (imem_resp_valid && !kill_q) begin
                  instPcWe = 1'b1;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  pcWe = 1'b1;
                  pc_d = pc_target;
               end else if (inst_ready) begin
                  pcWe = 1'b1;
                  pc_d = pc_q + XLEN'(PC_INC);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Fetch FSM with kill flag and registered IDU-side outputs; a misaligned
   // redirect from any live state halts the unit until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_REQ;
         kill_q        <= 1'b0;
         started_q     <= 1'b0;
         redirPend_q   <= 1'b0;
         redirTarget_q <= '0;
         instValid_q   <= 1'b0;
         inst_q        <= INST_LEN'(NOP_INST);
         fault_q       <= 1'b0;
      end else begin
         started_q <= 1'b1;
         if ((state_q != ST_FAULT) && misalign) begin
            state_q     <= ST_FAULT;
            fault_q     <= 1'b1;
            instValid_q <= 1'b0;
            kill_q      <= 1'b0;
            redirPend_q <= 1'b0;
         end else begin
            case (state_q)
               ST_REQ: begin
                  if (started_q) begin
                     if (imem_req_ready) begin
                        state_q     <= ST_WAIT;
                        kill_q      <= redirect || redirPend_q;
                        redirPend_q <= 1'b0;
                     end else if (redirect) begin
                        redirPend_q   <= 1'b1;
                        redirTarget_q <= pc_target;
                     end
                  end
               end
               ST_WAIT: begin
                  if (imem_resp_valid) begin
                     if (kill_q || redirect) begin
                        state_q <= ST_REQ;
                        kill_q  <= 1'b0;
                     end else begin
                        inst_q      <= imem_resp_data;
                        instValid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                     end
                  end else if (redirect) begin
                     kill_q <= 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (redirect || inst_ready) begin
                     instValid_q <= 1'b0;
                     state_q     <= ST_REQ;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   ysyx_22050039_PCReg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
      .clk_i  (clk),
      .rst_ni (rst),
      .wen_i  (pcWe),
      .d_i    (pc_d),
      .q_o    (pc_q)
   );

   ysyx_22050039_PCReg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_instpc (
      .clk_i  (clk),
      .rst_ni (rst),
      .wen_i  (instPcWe),
      .d_i    (pc_q),
      .q_o    (instPc_q)
   );

   assign imem_req_valid = (state_q == ST_REQ) && started_q;
   assign imem_req_addr  = pc_q;
   assign inst_valid     = instValid_q;
   assign inst           = inst_q;
   assign inst_pc        = instPc_q;
   assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Self-checking bench for ysyx_22050039_ifu: directed scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_ysyx_22050039_ifu;

   localparam logic [63:0] RESET_PC = 64'h8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        pc_wen = 1'b0;
   logic [63:0] pc_target = '0;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   int          memReadyMode = 0;
   int          memLatency   = 1;
   int          acceptCount  = 0;
   logic [63:0] lastAcceptAddr = '0;
   logic        pendValid = 1'b0;
   int          pendCnt = 0;
   logic [63:0] pendAddr = '0;
   logic        stallPrev = 1'b0;
   logic [63:0] stallAddr = '0;

   ysyx_22050039_ifu dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .pc_wen          (pc_wen),
      .pc_target       (pc_target),
      .fetch_fault     (fetch_fault)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Contents of instruction memory as a pure function of address.
   function automatic logic [31:0] memWord(input logic [63:0] a);
      if (a == 64'h8000_0000) return 32'h0010_0093;
      return a[31:0] ^ 32'h5A5A_0003;
   endfunction

   // Advance to just after the next falling edge, where outputs are stable.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Memory model: one response per accepted request after a latency, and
   // protocol checks on the request side (held address, single outstanding).
   initial begin
      forever begin
         @(negedge clk);
         imem_resp_valid = 1'b0;
         if (!rst) begin
            pendValid = 1'b0;
            stallPrev = 1'b0;
         end else begin
            if (pendValid) begin
               pendCnt = pendCnt - 1;
               if (pendCnt == 0) begin
                  imem_resp_valid = 1'b1;
                  imem_resp_data  = memWord(pendAddr);
                  pendValid       = 1'b0;
               end
            end
            case (memReadyMode)
               0:       imem_req_ready = 1'b1;
               1:       imem_req_ready = ($urandom_range(0, 1) == 1);
               default: imem_req_ready = 1'b0;
            endcase
            if (stallPrev && !fetch_fault) begin
               checks++;
               if (!(imem_req_valid && imem_req_addr == stallAddr)) begin
                  errors++;
                  $display("[TB] FAIL req_hold: valid=%0b addr=%h required valid=1 addr=%h",
                           imem_req_valid, imem_req_addr, stallAddr);
               end
            end
            stallPrev = imem_req_valid && !imem_req_ready;
            stallAddr = imem_req_addr;
            if (imem_req_valid && imem_req_ready) begin
               checks++;
               if (pendValid) begin
                  errors++;
                  $display("[TB] FAIL single_outstanding: new request %h while %h pending",
                           imem_req_addr, pendAddr);
               end
               pendValid      = 1'b1;
               pendAddr       = imem_req_addr;
               pendCnt        = (memLatency == 0) ? $urandom_range(1, 3) : memLatency;
               acceptCount    = acceptCount + 1;
               lastAcceptAddr = imem_req_addr;
            end
         end
      end
   end

   task automatic doReset();
      rst          = 1'b0;
      pc_wen       = 1'b0;
      pc_target    = '0;
      inst_ready   = 1'b0;
      memReadyMode = 0;
      memLatency   = 1;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic waitValid(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         step();
         if (inst_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b required 0", imem_req_valid); end
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b required 0", inst_valid); end
      checks++;
      if (inst !== NOP) begin errors++; $display("[TB] FAIL reset_inst: got %h required %h", inst, NOP); end
      checks++;
      if (inst_pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_inst_pc: got %h required %h", inst_pc, RESET_PC); end
      checks++;
      if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b required 0", fetch_fault); end
      rst = 1'b1;
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         errors++;
         $display("[TB] FAIL first_request: valid=%b addr=%h required valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
      end
   endtask

   task automatic test_zero_wait();
      doReset();
      inst_ready = 1'b1;
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         errors++; $display("[TB] FAIL zw_request: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      step();
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_wait_valid: got %b required 0", inst_valid); end
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== RESET_PC) begin
         errors++;
         $display("[TB] FAIL zw_inst: valid=%b inst=%h pc=%h required 1 00100093 %h", inst_valid, inst, inst_pc, RESET_PC);
      end
      step();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC + 64'd4) begin
         errors++; $display("[TB] FAIL zw_next_request: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RESET_PC + 64'd4);
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit          ok;
      logic [31:0] heldInst;
      logic [63:0] heldPc;
      doReset();
      waitValid(20, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL bp_first_valid: got no inst_valid required one within 20 cycles"); end
      heldInst = memWord(RESET_PC);
      heldPc   = RESET_PC;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (inst_valid !== 1'b1 || inst !== heldInst || inst_pc !== heldPc || imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold_%0d: valid=%b inst=%h pc=%h req=%b required 1 %h %h 0",
                     i, inst_valid, inst, inst_pc, imem_req_valid, heldInst, heldPc);
         end
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== heldPc + 64'd4) begin
         errors++; $display("[TB] FAIL bp_release: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, heldPc + 64'd4);
      end
   endtask

   task automatic test_req_stall();
      int base;
      doReset();
      memReadyMode = 2;
      base = acceptCount;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || acceptCount != base) begin
            errors++;
            $display("[TB] FAIL stall_%0d: valid=%b addr=%h accepts=%0d required 1 %h %0d",
                     i, imem_req_valid, imem_req_addr, acceptCount - base, RESET_PC, 0);
         end
      end
      memReadyMode = 0;
      step();
      step();
      checks++;
      if (acceptCount != base + 1 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_single: accepts=%0d valid=%b required 1 0", acceptCount - base, imem_req_valid);
      end
   endtask

   task automatic test_redirect_wait();
      bit ok;
      doReset();
      memLatency = 4;
      inst_ready = 1'b1;
      step();
      step();
      pc_wen    = 1'b1;
      pc_target = 64'h8000_0100;
      step();
      pc_wen = 1'b0;
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_no_early: got %b required 0", inst_valid); end
      waitValid(30, ok);
      checks++;
      if (!ok || inst_pc !== 64'h8000_0100 || inst !== memWord(64'h8000_0100) || lastAcceptAddr !== 64'h8000_0100) begin
         errors++;
         $display("[TB] FAIL rw_target: ok=%b pc=%h inst=%h lastreq=%h required 1 %h %h %h",
                  ok, inst_pc, inst, lastAcceptAddr, 64'h8000_0100, memWord(64'h8000_0100), 64'h8000_0100);
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_redirect_hold();
      bit ok;
      doReset();
      waitValid(20, ok);
      pc_wen     = 1'b1;
      pc_target  = 64'h8000_0040;
      inst_ready = 1'b1;
      step();
      pc_wen     = 1'b0;
      inst_ready = 1'b0;
      checks++;
      if (!ok || inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0040) begin
         errors++;
         $display("[TB] FAIL rh_request: ok=%b ivalid=%b req=%b addr=%h required 1 0 1 %h",
                  ok, inst_valid, imem_req_valid, imem_req_addr, 64'h8000_0040);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      doReset();
      waitValid(20, ok);
      pc_wen    = 1'b1;
      pc_target = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      pc_wen     = 1'b0;
      inst_ready = 1'b1;
      waitValid(20, ok);
      checks++;
      if (!ok || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst !== memWord(64'hFFFF_FFFF_FFFF_FFFC)) begin
         errors++; $display("[TB] FAIL wrap_inst: ok=%b pc=%h inst=%h required 1 fffffffffffffffc", ok, inst_pc, inst);
      end
      step();
      inst_ready = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
         errors++; $display("[TB] FAIL wrap_request: valid=%b addr=%h required 1 0", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_fault();
      doReset();
      memLatency = 4;
      step();
      step();
      pc_wen    = 1'b1;
      pc_target = 64'h8000_0002;
      step();
      pc_wen = 1'b0;
      checks++;
      if (fetch_fault !== 1'b1 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fault_set: fault=%b ivalid=%b req=%b required 1 0 0", fetch_fault, inst_valid, imem_req_valid);
      end
      inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fault_sticky_%0d: fault=%b req=%b ivalid=%b required 1 0 0", i, fetch_fault, imem_req_valid, inst_valid);
         end
      end
      inst_ready = 1'b0;
   endtask

   task automatic test_reset_midwait();
      int base;
      doReset();
      inst_ready = 1'b1;
      base = acceptCount;
      for (int i = 0; i < 20 && acceptCount < base + 3; i++) step();
      step();
      checks++;
      if (acceptCount != base + 3 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== RESET_PC + 64'd4) begin
         errors++;
         $display("[TB] FAIL midwait_setup: accepts=%0d req=%b ivalid=%b pc=%h required 3 0 0 %h",
                  acceptCount - base, imem_req_valid, inst_valid, inst_pc, RESET_PC + 64'd4);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || inst_pc !== RESET_PC || fetch_fault !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midwait_reset: req=%b ivalid=%b inst=%h pc=%h fault=%b required 0 0 %h %h 0",
                  imem_req_valid, inst_valid, inst, inst_pc, fetch_fault, NOP, RESET_PC);
      end
      inst_ready = 1'b0;
   endtask

   // Randomized run: every presented instruction must be the next one of
   // the architectural stream, which advances by 4 per consumed instruction
   // and jumps to the target on every redirect.
   task automatic test_random();
      logic [63:0] expectedPc;
      int          since;
      int          idle;
      int          delivered;
      bit          sawValid;
      bit          doRedir;
      logic [63:0] target;
      doReset();
      memReadyMode = 1;
      memLatency   = 0;
      expectedPc   = RESET_PC;
      since        = 100;
      idle         = 0;
      delivered    = 0;
      for (int n = 0; n < 800; n++) begin
         step();
         since++;
         sawValid = inst_valid;
         if (sawValid) begin
            idle = 0;
            checks++;
            if (inst_pc !== expectedPc || inst !== memWord(expectedPc)) begin
               errors++;
               $display("[TB] FAIL rand_stream: pc=%h inst=%h required %h %h", inst_pc, inst, expectedPc, memWord(expectedPc));
            end
            checks++;
            if (since < 3) begin
               errors++;
               $display("[TB] FAIL rand_penalty: valid %0d cycles after redirect required >= 3", since);
            end
         end else begin
            idle++;
            if (idle > 40) begin
               checks++;
               errors++;
               $display("[TB] FAIL rand_progress: %0d idle cycles required <= 40", idle);
               break;
            end
         end
         inst_ready = ($urandom_range(0, 1) == 1);
         doRedir    = ($urandom_range(0, 19) == 0);
         target     = RESET_PC + 64'({$urandom_range(0, 255), 2'b00});
         pc_wen     = doRedir;
         pc_target  = target;
         if (doRedir) begin
            expectedPc = target;
            since      = 0;
         end else if (sawValid && inst_ready) begin
            expectedPc = expectedPc + 64'd4;
            delivered++;
         end
      end
      pc_wen     = 1'b0;
      inst_ready = 1'b0;
      checks++;
      if (delivered < 20) begin
         errors++; $display("[TB] FAIL rand_delivered: got %0d instructions required >= 20", delivered);
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_req_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_fault();
      test_reset_midwait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time bound so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
